pk_loader: RTL and testbench

- Upstream stage of decode_pk. Deserialises an encoded ML-KEM public key, streamed as fixed-width words over a valid/ready interface, into one wide public_key register. decode_pk consumes that register combinationally.
- Layout: word 0 lands in bits [WORD_W-1:0], so rho occupies bits [255:0] and the t polynomials follow in ascending order.
- Holds pk_valid until the consumer acknowledges it.

---
 rtl/pk_loader_pkg.sv | 27 ++
 rtl/pk_loader_if.sv | 27 ++
 rtl/pk_coeff_check.sv | 23 ++
 rtl/pk_loader.sv | 144 ++++++++++++++
 tb/tb_pk_loader.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/pk_loader_pkg.sv
// Shared ML-KEM constants, key width and loader state type for pk_loader and decode_pk.
// PK_CHECK_EN adds the CHECK state used by the optional coefficient-range scan.
package pk_loader_pkg;

    localparam int KYBER_N       = 256;
    localparam int KYBER_K       = 3;
    localparam int KYBER_R_WIDTH = 12;
    localparam int KYBER_Q       = 3329;

    // decode_pk sizes its public_key input from this, so both ends always agree
    localparam int PK_WIDTH = KYBER_N + KYBER_K * KYBER_R_WIDTH * KYBER_N;

    localparam int CHK_LANES  = 8;
    localparam int CHK_BITS   = CHK_LANES * KYBER_R_WIDTH;
    localparam int CHK_CYCLES = (KYBER_K * KYBER_N) / CHK_LANES;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DONE  = 2'd2
`ifdef PK_CHECK_EN
        ,
        ST_CHECK = 2'd3
`endif
    } pk_state_e;

endpackage

// File: rtl/pk_loader_if.sv
// Word stream into the loader plus the assembled-key handoff towards decode_pk.
// master = producer/consumer side, slave = the loader.
interface pk_loader_if
    import pk_loader_pkg::*;
#(
    parameter int WORD_W = 32,
    parameter int PK_W   = PK_WIDTH
) ();

    logic [WORD_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [PK_W-1:0]   public_key;
    logic              pk_valid;
    logic              pk_ack;

    modport master (
        output in_data, in_valid, pk_ack,
        input  in_ready, public_key, pk_valid
    );

    modport slave (
        input  in_data, in_valid, pk_ack,
        output in_ready, public_key, pk_valid
    );

endinterface

// File: rtl/pk_coeff_check.sv
// Combinational 8-lane "coefficient >= q" compare, OR-reduced to one flag.
// Only compiled when PK_CHECK_EN is defined.
`ifdef PK_CHECK_EN
module pk_coeff_check
    import pk_loader_pkg::*;
#(
    parameter int NUM_LANES = CHK_LANES,
    parameter int COEF_W    = KYBER_R_WIDTH
) (
    input  logic [NUM_LANES-1:0][COEF_W-1:0] coef,
    output logic                             any_bad
);

    logic [NUM_LANES-1:0] bad;

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        assign bad[l] = (coef[l] >= COEF_W'(KYBER_Q));
    end

    assign any_bad = |bad;

endmodule
`endif

// File: rtl/pk_loader.sv
// Deserialises a streamed ML-KEM public key into one wide register for decode_pk.
// Optional PK_CHECK_EN adds a CHECK pass that flags t coefficients >= q on pk_err.
module pk_loader
    import pk_loader_pkg::*;
#(
    parameter  int WORD_W    = 32,
    parameter  int PK_W      = PK_WIDTH,
    localparam int NUM_WORDS = PK_W / WORD_W
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    pk_loader_if.slave  bus,
    output logic        busy,
    output logic        pk_err
);

    localparam int                CNT_W    = $clog2(NUM_WORDS);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(NUM_WORDS - 1);

    pk_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [PK_W-1:0]   key_q;
    logic              cnt_clr;
    logic              xfer;
    logic              in_ready;
    logic              pk_valid;

`ifdef PK_CHECK_EN
    localparam int               CHK_W    = $clog2(CHK_CYCLES);
    localparam logic [CHK_W-1:0] CHK_LAST = CHK_W'(CHK_CYCLES - 1);

    logic [CHK_W-1:0]                             chk_q;
    logic                                         err_q;
    logic                                         lane_bad;
    logic [CHK_LANES-1:0][KYBER_R_WIDTH-1:0]      coef;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        cnt_clr  = 1'b0;
        xfer     = 1'b0;
        in_ready = 1'b0;
        pk_valid = 1'b0;
        busy     = (state_q != ST_IDLE);
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LOAD;
                    cnt_clr = 1'b1;
                end
            end
            ST_LOAD: begin
                in_ready = 1'b1;
                // a restart discards whatever word is on the bus this cycle
                if (start) begin
                    cnt_clr = 1'b1;
                end else if (bus.in_valid) begin
                    xfer = 1'b1;
                    if (cnt_q == CNT_LAST) begin
`ifdef PK_CHECK_EN
                        state_d = ST_CHECK;
`else
                        state_d = ST_DONE;
`endif
                    end
                end
            end
`ifdef PK_CHECK_EN
            ST_CHECK: begin
                if (start) begin
                    state_d = ST_LOAD;
                    cnt_clr = 1'b1;
                end else if (chk_q == CHK_LAST) begin
                    state_d = ST_DONE;
                end
            end
`endif
            ST_DONE: begin
                pk_valid = 1'b1;
                if (start) begin
                    state_d = ST_LOAD;
                    cnt_clr = 1'b1;
                end else if (bus.pk_ack) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Unwritten words keep stale data; pk_valid is the only completeness marker.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            key_q <= '0;
        end else if (cnt_clr) begin
            cnt_q <= '0;
        end else if (xfer) begin
            key_q[int'(cnt_q)*WORD_W +: WORD_W] <= bus.in_data;
            if (cnt_q != CNT_LAST) cnt_q <= cnt_q + 1'b1;
        end
    end

`ifdef PK_CHECK_EN
    assign coef = key_q[KYBER_N + int'(chk_q)*CHK_BITS +: CHK_BITS];

    pk_coeff_check #(
        .NUM_LANES (CHK_LANES),
        .COEF_W    (KYBER_R_WIDTH)
    ) u_chk (
        .coef    (coef),
        .any_bad (lane_bad)
    );

    // pk_err is sticky across the scan and only cleared by the next start
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chk_q <= '0;
            err_q <= 1'b0;
        end else if (start) begin
            chk_q <= '0;
            err_q <= 1'b0;
        end else if (state_q == ST_CHECK) begin
            if (chk_q != CHK_LAST) chk_q <= chk_q + 1'b1;
            if (lane_bad) err_q <= 1'b1;
        end
    end

    assign pk_err = err_q;
`else
    assign pk_err = 1'b0;
`endif

    assign bus.in_ready   = in_ready;
    assign bus.pk_valid   = pk_valid;
    assign bus.public_key = key_q;

endmodule

// File: tb/tb_pk_loader.sv
// Directed bench for pk_loader: full loads, stalls, DONE hold, restart, async reset.
// With PK_CHECK_EN defined it also exercises the coefficient-range scan.
module tb_pk_loader;
    import pk_loader_pkg::*;

    localparam int WW = 32;
    localparam int NW = PK_WIDTH / WW;
`ifdef PK_CHECK_EN
    localparam int EXTRA = CHK_CYCLES;
`else
    localparam int EXTRA = 0;
`endif

    logic clk;
    logic rst;
    logic start;
    logic busy;
    logic pk_err;

    pk_loader_if #(.WORD_W(WW), .PK_W(PK_WIDTH)) ifc ();

    pk_loader #(.WORD_W(WW), .PK_W(PK_WIDTH)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .bus    (ifc.slave),
        .busy   (busy),
        .pk_err (pk_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int total = 0;
    int bad   = 0;
    int ticks = 0;
    int rdy_low;
    int early_valid;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        ticks++;
    endtask

    function automatic logic [PK_WIDTH-1:0] make_key(input logic [31:0] pat);
        logic [PK_WIDTH-1:0] k;
        k = '0;
        for (int i = 0; i < NW; i++) k[i*WW +: WW] = pat | 32'(i);
        return k;
    endfunction

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic ack();
        ifc.pk_ack = 1'b1;
        tick();
        ifc.pk_ack = 1'b0;
    endtask

    // drive words from src; gaps drops in_valid on every third cycle
    task automatic stream(input string tag, input logic [PK_WIDTH-1:0] src, input int n, input bit gaps);
        int i = 0;
        int c = 0;
        rdy_low = 0;
        early_valid = 0;
        while (i < n && c < 4*NW) begin
            ifc.in_valid = !(gaps && (c % 3 == 2));
            ifc.in_data  = src[i*WW +: WW];
            if (!ifc.in_ready) rdy_low++;
            if (ifc.pk_valid)  early_valid++;
            if (ifc.in_valid && ifc.in_ready) i++;
            tick();
            c++;
        end
        ifc.in_valid = 1'b0;
        check({tag, "_words"}, 64'(i), 64'(n));
        check({tag, "_rdy_low"}, 64'(rdy_low), 64'd0);
        check({tag, "_early_valid"}, 64'(early_valid), 64'd0);
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        int rdy = 0;
        while (!ifc.pk_valid && n < 400) begin
            if (ifc.in_ready) rdy++;
            tick();
            n++;
        end
        check({tag, "_wait"}, 64'(n), 64'(EXTRA));
        check({tag, "_rdy_in_check"}, 64'(rdy), 64'd0);
    endtask

    initial begin
        logic [PK_WIDTH-1:0] exp_key;
        logic [PK_WIDTH-1:0] k2;
        int t0;
        int hold_bad;

        rst = 1'b1;
        start = 1'b0;
        ifc.in_valid = 1'b0;
        ifc.in_data = '0;
        ifc.pk_ack = 1'b0;

        #3;
        check("rst_pk_valid", 64'(ifc.pk_valid), 64'd0);
        check("rst_in_ready", 64'(ifc.in_ready), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_pk_err", 64'(pk_err), 64'd0);
        check("rst_key_zero", 64'(ifc.public_key == '0), 64'd1);
        tick();
        tick();
        rst = 1'b0;
        tick();
        // in_valid in IDLE must not start anything
        ifc.in_valid = 1'b1;
        ifc.in_data = 32'h1234_5678;
        tick();
        ifc.in_valid = 1'b0;
        check("idle_busy", 64'(busy), 64'd0);
        check("idle_key", 64'(ifc.public_key == '0), 64'd1);

        // full load, no stalls
        exp_key = make_key(32'hA500_0000);
        t0 = ticks;
        do_start();
        stream("t1", exp_key, NW, 1'b0);
        wait_valid("t1");
        check("t1_latency", 64'(ticks - t0), 64'(297 + EXTRA));
        check("t1_pk_valid", 64'(ifc.pk_valid), 64'd1);
        check("t1_busy", 64'(busy), 64'd1);
        check("t1_in_ready", 64'(ifc.in_ready), 64'd0);
        check("t1_word0", 64'(ifc.public_key[31:0]), 64'hA500_0000);
        check("t1_word_last", 64'(ifc.public_key[9471:9440]), 64'hA500_0127);
        check("t1_rho", 64'(ifc.public_key[255:0] == exp_key[255:0]), 64'd1);
        check("t1_key", 64'(ifc.public_key == exp_key), 64'd1);
        check("t1_pk_err", 64'(pk_err), 64'd0);
        ack();
        check("t1_ack_busy", 64'(busy), 64'd0);
        check("t1_ack_valid", 64'(ifc.pk_valid), 64'd0);

        // same key with in_valid low every third cycle
        t0 = ticks;
        do_start();
        stream("t2", exp_key, NW, 1'b1);
        wait_valid("t2");
        check("t2_latency", 64'(ticks - t0), 64'(444 + EXTRA));
        check("t2_key", 64'(ifc.public_key == exp_key), 64'd1);

        // hold in DONE with in_valid noise, then acknowledge
        hold_bad = 0;
        for (int c = 0; c < 50; c++) begin
            ifc.in_valid = c[0];
            ifc.in_data = 32'hDEAD_BEEF;
            if (!ifc.pk_valid || ifc.public_key != exp_key || ifc.in_ready) hold_bad++;
            tick();
        end
        ifc.in_valid = 1'b0;
        check("t3_hold", 64'(hold_bad), 64'd0);
        check("t3_key_after_hold", 64'(ifc.public_key == exp_key), 64'd1);
        ack();
        check("t3_ack_busy", 64'(busy), 64'd0);
        check("t3_ack_valid", 64'(ifc.pk_valid), 64'd0);

        // restart after 100 words; the word beside the restart pulse is dropped
        do_start();
        stream("t4a", make_key(32'h5A00_0000), 100, 1'b0);
        start = 1'b1;
        ifc.in_valid = 1'b1;
        ifc.in_data = 32'hFFFF_FFFF;
        tick();
        start = 1'b0;
        ifc.in_valid = 1'b0;
        k2 = '0;
        t0 = ticks;
        stream("t4b", k2, NW, 1'b0);
        wait_valid("t4");
        check("t4_latency", 64'(ticks - t0), 64'(296 + EXTRA));
        check("t4_key_zero", 64'(ifc.public_key == '0), 64'd1);

        // start together with pk_ack in DONE: start wins
        start = 1'b1;
        ifc.pk_ack = 1'b1;
        tick();
        start = 1'b0;
        ifc.pk_ack = 1'b0;
        check("t5_start_wins_ready", 64'(ifc.in_ready), 64'd1);
        check("t5_start_wins_valid", 64'(ifc.pk_valid), 64'd0);
        check("t5_start_wins_busy", 64'(busy), 64'd1);

        // async reset after 150 words, no clock edge in between
        stream("t5a", exp_key, 150, 1'b0);
        #2 rst = 1'b1;
        #1;
        check("t5_rst_valid", 64'(ifc.pk_valid), 64'd0);
        check("t5_rst_ready", 64'(ifc.in_ready), 64'd0);
        check("t5_rst_busy", 64'(busy), 64'd0);
        check("t5_rst_key", 64'(ifc.public_key == '0), 64'd1);
        tick();
        tick();
        rst = 1'b0;
        tick();
        t0 = ticks;
        do_start();
        stream("t5b", exp_key, NW, 1'b0);
        wait_valid("t5");
        check("t5_latency", 64'(ticks - t0), 64'(297 + EXTRA));
        check("t5_key", 64'(ifc.public_key == exp_key), 64'd1);
        ack();

`ifdef PK_CHECK_EN
        // first t coefficient = q
        k2 = '0;
        k2[267:256] = 12'hD01;
        do_start();
        stream("c1", k2, NW, 1'b0);
        wait_valid("c1");
        check("c1_pk_err", 64'(pk_err), 64'd1);
        check("c1_pk_valid", 64'(ifc.pk_valid), 64'd1);
        ack();
        // every t coefficient = q-1
        k2 = '0;
        for (int j = 0; j < KYBER_K*KYBER_N; j++) k2[KYBER_N + j*KYBER_R_WIDTH +: KYBER_R_WIDTH] = 12'hD00;
        do_start();
        stream("c2", k2, NW, 1'b0);
        wait_valid("c2");
        check("c2_pk_err", 64'(pk_err), 64'd0);
        check("c2_key", 64'(ifc.public_key == k2), 64'd1);
        ack();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
